// File: rtl/trigger_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_ctrl_pkg
//  Purpose  : Shared definitions for the capture trigger controller. The
//             capture-memory geometry and the state codes live here so
//             host-side readback decodes the same values the RTL produces.
//  Revision : 1.0 - initial release
// ============================================================================
package trigger_ctrl_pkg;

  // Default capture-memory address width; memory depth is 2**width.
  localparam int DEFAULT_ADDR_WIDTH  = 4;
  localparam int DEFAULT_MEMORY_SIZE = 2 ** DEFAULT_ADDR_WIDTH;

  // Width of the debug state code.
  localparam int STATE_W = 3;

  // State codes, also reported on the debug 'state' port.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  // Memory depth for a given address width.
  function automatic int mem_size(input int addr_width);
    return 2 ** addr_width;
  endfunction

endpackage : trigger_ctrl_pkg
`default_nettype wire

// File: rtl/trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_ctrl
//  Purpose  : Capture trigger controller. Clears the capture memory, lets the
//             writer fill the full pre-trigger history, accepts a trigger,
//             stores post_len further samples and then streams the whole
//             memory out oldest-first with a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module trigger_ctrl
  import trigger_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig,
  input  logic [ADDR_WIDTH-1:0] post_len,
  input  logic                  primed,
  input  logic [ADDR_WIDTH-1:0] waddr,
  output logic                  write_enable,
  output logic                  mem_reset,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  busy,
  output logic [STATE_W-1:0]    state
);

  localparam int MEMORY_SIZE = mem_size(ADDR_WIDTH);

  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_last_beat = ADDR_WIDTH'(MEMORY_SIZE - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_beat;

  // Address of the oldest sample once the current write has landed: the
  // writer advances waddr after every strobe, so this is waddr + 1.
  logic [ADDR_WIDTH-1:0] w_oldest;
  assign w_oldest = waddr + c_addr_one;

  // Controller state machine; abort wins over every other request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_trig_addr <= '0;
      r_raddr     <= '0;
      r_cnt       <= '0;
      r_beat      <= '0;
    end else if (abort && (r_state != ST_IDLE)) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm && !abort) begin
            r_state <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          r_state <= ST_ARMED;
        end

        // Trigger is only honoured once the whole memory holds history.
        ST_ARMED: begin
          if (trig && primed) begin
            r_trig_addr <= waddr;
            r_cnt       <= post_len;
            if (post_len != '0) begin
              r_state <= ST_POST;
            end else begin
              r_state <= ST_READ;
              r_raddr <= w_oldest;
              r_beat  <= '0;
            end
          end
        end

        // The cycle with r_cnt == 1 carries the final post-trigger write.
        ST_POST: begin
          r_cnt <= r_cnt - c_addr_one;
          if (r_cnt == c_addr_one) begin
            r_state <= ST_READ;
            r_raddr <= w_oldest;
            r_beat  <= '0;
          end
        end

        // One address per accepted beat, wrapping through the whole memory.
        ST_READ: begin
          if (rd_ready) begin
            r_raddr <= r_raddr + c_addr_one;
            r_beat  <= r_beat + c_addr_one;
            if (r_beat == c_last_beat) begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded straight from the state register.
  assign write_enable = (r_state == ST_ARMED) || (r_state == ST_POST);
  assign mem_reset    = reset || (r_state == ST_CLEAR);
  assign rd_valid     = (r_state == ST_READ);
  assign rd_last      = (r_state == ST_READ) && (r_beat == c_last_beat);
  assign busy         = (r_state != ST_IDLE);
  assign state        = r_state;
  assign trig_addr    = r_trig_addr;
  assign raddr        = r_raddr;

endmodule : trigger_ctrl
`default_nettype wire

// File: tb/tb_trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trigger_ctrl
//  Purpose  : Self-checking bench for trigger_ctrl with a behavioural memory
//             writer and a readout scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_ctrl;

  localparam int AW  = 4;
  localparam int MEM = 2 ** AW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm;
  logic          abort;
  logic          trig;
  logic [AW-1:0] post_len;
  logic          primed;
  logic [AW-1:0] waddr;
  logic          write_enable;
  logic          mem_reset;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] raddr;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;
  logic          busy;
  logic [2:0]    state;

  int n_checks = 0;
  int n_errors = 0;
  int n_beats  = 0;

  // Expected readout beats: {last, addr}
  logic [AW:0] sb_q[$];

  trigger_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .trig         (trig),
    .post_len     (post_len),
    .primed       (primed),
    .waddr        (waddr),
    .write_enable (write_enable),
    .mem_reset    (mem_reset),
    .trig_addr    (trig_addr),
    .raddr        (raddr),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_last      (rd_last),
    .busy         (busy),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Behavioural memory writer: address advances on every strobe, primed
  // once the last location has been written.
  always_ff @(posedge clk) begin
    if (mem_reset) begin
      waddr  <= '0;
      primed <= 1'b0;
    end else if (write_enable) begin
      waddr <= waddr + 4'd1;
      if (waddr == 4'd15) primed <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the full readout expected from a given oldest address.
  task automatic push_readout(input int start);
    for (int i = 0; i < MEM; i++) begin
      logic [AW-1:0] a;
      a = AW'((start + i) % MEM);
      sb_q.push_back({(i == MEM - 1), a});
    end
  endtask

  // Stay in state st, counting write strobes, until it is left.
  task automatic run_until_leave(input logic [2:0] st, input string tag, output int n_we);
    int n;
    n = 0;
    n_we = 0;
    while (state == st && n < 200) begin
      if (write_enable) n_we++;
      tick();
      n++;
    end
    check({tag, "_timeout"}, (n >= 200), 0);
  endtask

  // Drain the readout; toggle selects a 1,0,1,... ready pattern.
  task automatic readout(input bit toggle, input string tag);
    int n;
    n = 0;
    n_beats = 0;
    rd_ready = 1'b1;
    while (state == S_READ && n < 200) begin
      tick();
      n++;
      if (toggle) rd_ready = ~rd_ready;
    end
    rd_ready = 1'b0;
    check({tag, "_timeout"}, (n >= 200), 0);
    check({tag, "_end_state"}, state, S_IDLE);
    check({tag, "_beats"}, n_beats, MEM);
    check({tag, "_sb_drained"}, sb_q.size(), 0);
  endtask

  // Readout monitor: compare each accepted beat with the scoreboard head,
  // and require raddr to hold while the consumer stalls.
  always @(negedge clk) begin
    if (rd_valid && rd_ready) begin
      check("sb_nonempty", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        logic [AW:0] e;
        e = sb_q.pop_front();
        check("beat_addr", raddr, e[AW-1:0]);
        check("beat_last", rd_last, e[AW]);
        n_beats++;
      end
    end else if (rd_valid && !rd_ready && sb_q.size() != 0) begin
      check("raddr_hold", raddr, sb_q[0][AW-1:0]);
    end
  end

  initial begin
    int n_we;

    reset = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
    rd_ready = 1'b0; post_len = '0;
    repeat (2) tick();

    // Reset state
    check("rst_state", state, S_IDLE);
    check("rst_busy", busy, 0);
    check("rst_we", write_enable, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_mem_reset", mem_reset, 1);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_raddr", raddr, 0);
    reset = 1'b0;
    tick();
    check("idle_mem_reset", mem_reset, 0);
    check("idle_state", state, S_IDLE);

    // Trigger held from arm, post_len=5: trigger at waddr 0, readout from 6
    post_len = 4'd5; trig = 1'b1; arm = 1'b1;
    push_readout((0 + 5 + 1) % MEM);
    tick();
    arm = 1'b0;
    check("s1_clear_state", state, S_CLEAR);
    check("s1_clear_mem_reset", mem_reset, 1);
    check("s1_clear_we", write_enable, 0);
    tick();
    check("s1_armed_state", state, S_ARMED);
    check("s1_armed_mem_reset", mem_reset, 0);
    run_until_leave(S_ARMED, "s1_armed", n_we);
    // 16 history writes, then the trigger write itself
    check("s1_armed_writes", n_we, MEM + 1);
    check("s1_post_state", state, S_POST);
    check("s1_trig_addr", trig_addr, 0);
    // Late arm and post_len changes must not disturb the capture
    arm = 1'b1; post_len = 4'd9;
    run_until_leave(S_POST, "s1_post", n_we);
    arm = 1'b0;
    check("s1_post_writes", n_we, 5);
    check("s1_read_state", state, S_READ);
    check("s1_read_raddr", raddr, 6);
    check("s1_read_valid", rd_valid, 1);
    check("s1_read_we", write_enable, 0);
    readout(1'b1, "s1_read");

    // post_len=0: straight from trigger to READ
    post_len = 4'd0; trig = 1'b1; arm = 1'b1;
    push_readout((0 + 0 + 1) % MEM);
    tick();
    arm = 1'b0;
    tick();
    run_until_leave(S_ARMED, "s2_armed", n_we);
    check("s2_armed_writes", n_we, MEM + 1);
    check("s2_read_state", state, S_READ);
    check("s2_read_we", write_enable, 0);
    check("s2_read_raddr", raddr, 1);
    readout(1'b0, "s2_read");

    // Abort while ARMED
    trig = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    check("s3_armed_state", state, S_ARMED);
    repeat (3) tick();
    check("s3_armed_we", write_enable, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s3_abort_state", state, S_IDLE);
    check("s3_abort_we", write_enable, 0);
    check("s3_abort_busy", busy, 0);
    // abort beats arm in IDLE
    arm = 1'b1; abort = 1'b1;
    tick();
    check("s3_arm_abort_state", state, S_IDLE);
    arm = 1'b0; abort = 1'b0;
    // abort beats a trigger that would otherwise be accepted
    trig = 1'b1; arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    repeat (MEM) tick();
    check("s3_trig_cycle_state", state, S_ARMED);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s3_abort_trig_state", state, S_IDLE);
    check("s3_abort_trig_valid", rd_valid, 0);

    // Late trigger at waddr 3, then reset in the middle of POST
    trig = 1'b0; post_len = 4'd10; arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    repeat (19) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("s4_post_state", state, S_POST);
    check("s4_trig_addr", trig_addr, 3);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("s4_rst_state", state, S_IDLE);
    check("s4_rst_we", write_enable, 0);
    check("s4_rst_mem_reset", mem_reset, 1);
    check("s4_rst_busy", busy, 0);
    check("s4_rst_trig_addr", trig_addr, 0);
    check("s4_rst_raddr", raddr, 0);
    tick();
    check("s4_rst_hold_mem_reset", mem_reset, 1);
    reset = 1'b0;
    tick();
    check("s4_release_mem_reset", mem_reset, 0);
    check("s4_release_state", state, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_trigger_ctrl
`default_nettype wire
